// File: rtl/ysyx_22041071_axi_w_arb.sv
// rtl/ysyx_22041071_axi_w_arb.sv - two-requester AXI write arbiter; optional macro YSYX_22041071_AXI_W_ARB_RR_EN selects round-robin
module ysyx_22041071_axi_w_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [63:0] req0_addr,
  input  logic [7:0]  req0_len,
  input  logic [1:0]  req0_size,
  input  logic [63:0] req0_data,
  output logic        req0_ready,
  output logic        req0_done,
  output logic [1:0]  req0_resp,
  input  logic        req1_valid,
  input  logic [63:0] req1_addr,
  input  logic [7:0]  req1_len,
  input  logic [1:0]  req1_size,
  input  logic [63:0] req1_data,
  output logic        req1_ready,
  output logic        req1_done,
  output logic [1:0]  req1_resp,
  output logic        cpu_aw_valid,
  output logic [3:0]  cpu_id,
  output logic [63:0] cpu_addr,
  output logic [7:0]  cpu_aw_len,
  output logic [1:0]  cpu_size,
  output logic [63:0] cpu_w_data,
  input  logic        cpu_aw_ready,
  input  logic [1:0]  cpu_w_resp,
  output logic        arb_busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] BUSY  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0] state;
  logic       any_valid;
  logic       win;
  logic       grant;
  logic       granted;

`ifdef YSYX_22041071_AXI_W_ARB_RR_EN
  logic       last_grant;

  // Remember who won last so a contested grant alternates
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (grant) begin
      last_grant <= win;
    end
  end

  // Pick the winner: lone request wins, contested goes to the one not served last
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      win = ~last_grant;
    end else begin
      win = req1_valid;
    end
  end
`else
  // Pick the winner: requester 0 always has priority
  always_comb begin
    any_valid = req0_valid | req1_valid;
    win       = ~req0_valid;
  end
`endif

  assign grant   = (state == IDLE) && any_valid;
  assign granted = cpu_id[0];

  // Transaction sequencing: grant, address issue, wait for engine, report
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (any_valid)    state <= ISSUE;
        ISSUE:   if (cpu_aw_ready) state <= BUSY;
        BUSY:    if (cpu_aw_ready) state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

  // Capture the winner's request; held until the transaction retires
  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_id     <= 4'd0;
      cpu_addr   <= 64'd0;
      cpu_aw_len <= 8'd0;
      cpu_size   <= 2'd0;
      cpu_w_data <= 64'd0;
    end else if (grant) begin
      cpu_id     <= {3'b000, win};
      cpu_addr   <= win ? req1_addr : req0_addr;
      cpu_aw_len <= win ? req1_len  : req0_len;
      cpu_size   <= win ? req1_size : req0_size;
      cpu_w_data <= win ? req1_data : req0_data;
    end
  end

  assign cpu_aw_valid = (state == ISSUE);
  assign arb_busy     = (state != IDLE);

  assign req0_ready = grant && !win;
  assign req1_ready = grant && win;
  assign req0_done  = (state == DONE) && !granted;
  assign req1_done  = (state == DONE) && granted;
  assign req0_resp  = req0_done ? cpu_w_resp : 2'b00;
  assign req1_resp  = req1_done ? cpu_w_resp : 2'b00;

endmodule
